mdu_engine: RTL and testbench

MDU_ENGINE -- requirements
Module: mdu_engine

---
 rtl/mdu_engine.sv | 188 ++++++++++++++++++
 tb/tb_mdu_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_engine.sv
// -----------------------------------------------------------------------------
// mdu_engine
// Multi-cycle multiply/divide unit for the E stage of a 5-stage pipeline.
// A mult/multu/div/divu issued while idle latches its operands, holds busy for
// MULT_CYCLES or DIV_CYCLES cycles, and commits HI/LO on the edge busy falls.
// mthi/mtlo write E_A directly when idle; mfhi/mflo read back combinationally.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-high reset
//   E_MDU_op     in   5   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                         5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
//   E_A          in  32   rs operand (forwarded)
//   E_B          in  32   rt operand (forwarded)
//   busy         out  1   multi-cycle operation in flight
//   E_real_busy  out  1   busy OR start, for D-stage stall logic
//   E_MDU_out    out 32   mfhi/mflo read data
//   HI           out 32   committed HI register
//   LO           out 32   committed LO register
// -----------------------------------------------------------------------------
module mdu_engine #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  E_MDU_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        busy,
    output logic        E_real_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic             is_md_s;
    logic             start_s;
    logic             is_div_s;
    logic             signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [31:0]      a_mag_s;
    logic [31:0]      b_mag_s;
    logic [31:0]      b_safe_s;
    logic [31:0]      q_mag_s;
    logic [31:0]      r_mag_s;
    logic [31:0]      quo_s;
    logic [31:0]      rem_s;
    logic [63:0]      prod_s;
    logic [31:0]      hi_nxt_s;
    logic [31:0]      lo_nxt_s;
    logic             wr_s;

    assign is_md_s     = (E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU) ||
                         (E_MDU_op == OP_DIV)  || (E_MDU_op == OP_DIVU);
    assign start_s     = is_md_s && (state_r == ST_IDLE);
    assign busy        = (state_r == ST_RUN);
    assign E_real_busy = busy || start_s;
    assign HI          = hi_r;
    assign LO          = lo_r;

    // Signedness of the latched op and operand magnitudes for the datapath.
    assign is_div_s = (op_r == OP_DIV) || (op_r == OP_DIVU);
    assign signed_s = (op_r == OP_MULT) || (op_r == OP_DIV);
    assign a_neg_s  = signed_s && a_r[31];
    assign b_neg_s  = signed_s && b_r[31];
    assign a_mag_s  = a_neg_s ? (~a_r + 32'd1) : a_r;
    assign b_mag_s  = b_neg_s ? (~b_r + 32'd1) : b_r;

    // Sign-extending to 64 bits makes one unsigned multiply serve both
    // mult and multu: the low 64 bits are the product modulo 2^64.
    assign prod_s = {{32{a_neg_s}}, a_r} * {{32{b_neg_s}}, b_r};

    // Divide on magnitudes so truncation is toward zero and the remainder
    // follows the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    // A zero divisor is replaced by 1 purely to keep the datapath defined;
    // its result is never committed.
    assign b_safe_s = (b_r == 32'd0) ? 32'd1 : b_mag_s;
    assign q_mag_s  = a_mag_s / b_safe_s;
    assign r_mag_s  = a_mag_s % b_safe_s;
    assign quo_s    = (a_neg_s ^ b_neg_s) ? (~q_mag_s + 32'd1) : q_mag_s;
    assign rem_s    = a_neg_s ? (~r_mag_s + 32'd1) : r_mag_s;

    // Select the HI/LO values committed when the operation completes.
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        wr_s     = 1'b0;
        if (is_div_s) begin
            hi_nxt_s = rem_s;
            lo_nxt_s = quo_s;
            wr_s     = (b_r != 32'd0);
        end else begin
            hi_nxt_s = prod_s[63:32];
            lo_nxt_s = prod_s[31:0];
            wr_s     = 1'b1;
        end
    end

    // mfhi/mflo read mux.
    always_comb begin
        case (E_MDU_op)
            OP_MFHI: E_MDU_out = hi_r;
            OP_MFLO: E_MDU_out = lo_r;
            default: E_MDU_out = 32'd0;
        endcase
    end

    // Control FSM, operand latch, countdown and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 5'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_RUN;
                        op_r    <= E_MDU_op;
                        a_r     <= E_A;
                        b_r     <= E_B;
                        if ((E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU)) begin
                            cnt_r <= CNT_W'(MULT_CYCLES);
                        end else begin
                            cnt_r <= CNT_W'(DIV_CYCLES);
                        end
                    end else if (E_MDU_op == OP_MTHI) begin
                        hi_r <= E_A;
                    end else if (E_MDU_op == OP_MTLO) begin
                        lo_r <= E_A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Everything presented on E_MDU_op is ignored here.
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        if (wr_s) begin
                            hi_r <= hi_nxt_s;
                            lo_r <= lo_nxt_s;
                        end else begin
                            hi_r <= hi_r;
                            lo_r <= lo_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_engine.sv
module tb_mdu_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  E_MDU_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        busy;
    logic        E_real_busy;
    logic [31:0] E_MDU_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec  = 0;
    int n_fail = 0;

    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[13];

    mdu_engine #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .E_MDU_op    (E_MDU_op),
        .E_A         (E_A),
        .E_B         (E_B),
        .busy        (busy),
        .E_real_busy (E_real_busy),
        .E_MDU_out   (E_MDU_out),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDU_op = op;
        E_A      = a;
        E_B      = b;
    endtask

    // Called at the negedge of the issue cycle with the op already driven.
    task automatic wait_check(input string name, input logic [31:0] hi,
                              input logic [31:0] lo, input int cyc);
        int n;
        int rb;
        #1;
        chk({name, " real_busy@start"}, {31'd0, E_real_busy}, (cyc != 0) ? 32'd1 : 32'd0);
        rb = E_real_busy ? 1 : 0;
        @(negedge clk);
        E_MDU_op = OP_NONE;
        E_A      = 32'hDEAD_BEEF;
        E_B      = 32'hCAFE_F00D;
        n = 0;
        #1;
        while (busy && n < 100) begin
            n++;
            if (E_real_busy) rb++;
            @(negedge clk);
            #1;
        end
        chk({name, " busy cycles"}, n, cyc);
        chk({name, " real_busy cycles"}, rb, (cyc != 0) ? cyc + 1 : 0);
        chk({name, " HI"}, HI, hi);
        chk({name, " LO"}, LO, lo);
        E_MDU_op = OP_MFHI;
        #1;
        chk({name, " mfhi"}, E_MDU_out, hi);
        E_MDU_op = OP_MFLO;
        #1;
        chk({name, " mflo"}, E_MDU_out, lo);
        E_MDU_op = OP_NONE;
    endtask

    initial begin
        int n;
        vecs[0]  = '{"mult -2*3",       OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{"multu max*max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{"div -7/2",        OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"div min/-1",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4]  = '{"divu 100/7",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[5]  = '{"mult min*min",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[6]  = '{"multu 2^31*2",    OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};
        vecs[7]  = '{"div 7/-2",        OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{"mult pos",        OP_MULT,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5};
        vecs[9]  = '{"divu max/16",     OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[10] = '{"mthi 0x11",       OP_MTHI,  32'h00000011, 32'h0,        32'h00000011, 32'h0FFFFFFF, 0};
        vecs[11] = '{"mtlo 0x22",       OP_MTLO,  32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
        vecs[12] = '{"divu 5/0",        OP_DIVU,  32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};

        reset = 1'b1;
        drive(OP_NONE, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset real_busy", {31'd0, E_real_busy}, 32'd0);
        chk("reset mdu_out", E_MDU_out, 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_check(vecs[i].name, vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // mt/mult presented while busy, operands wiggled: must be ignored.
        @(negedge clk);
        drive(OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        n = 0;
        #1;
        while (busy && n < 100) begin
            n++;
            case (n)
                1:       drive(OP_MTLO, 32'h55, 32'h0);
                2:       drive(OP_MULT, 32'd9, 32'd9);
                3:       drive(OP_MTHI, 32'h77, 32'h5);
                default: drive(OP_NONE, 32'hFFFF0000, 32'h0000FFFF);
            endcase
            @(negedge clk);
            #1;
        end
        chk("busy-ignore cycles", n, 5);
        chk("busy-ignore LO", LO, 32'd12);
        chk("busy-ignore HI", HI, 32'd0);

        // Reset in busy cycle 3 of a div; start ignored during reset.
        @(negedge clk);
        drive(OP_MTHI, 32'hA5A5A5A5, 32'd0);
        @(negedge clk);
        drive(OP_DIV, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        drive(OP_NONE, 32'd0, 32'd0);
        #1;
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid-reset busy", {31'd0, busy}, 32'd0);
        chk("mid-reset HI", HI, 32'd0);
        chk("mid-reset LO", LO, 32'd0);
        @(negedge clk);
        drive(OP_MULT, 32'd6, 32'd7);
        @(negedge clk);
        #1;
        chk("start during reset", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_check("mult after reset", 32'd0, 32'd42, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
